div_clk_checker: RTL and testbench

Checks a divided clock against the master clock. It samples a divided signal (for example the `q` output of the divide-by-two flip-flop) on the master clock `cl` and measures its rise-to-rise period in `cl` cycles. It declares lock after a run of correct periods and flags wrong-period and stalled-clock errors. It sits beside any clock divider in the design as a built-in self-check and debug aid.

---
 rtl/div_clk_checker.sv | 145 ++++++++++++++
 tb/tb_div_clk_checker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/div_clk_checker.sv
// rtl/div_clk_checker.sv - divided-clock period checker with lock and stall detection
module div_clk_checker #(
  parameter int DIV      = 2,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             cl,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] STALL_C = CNT_W'(2 * DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       LOCK_C  = 4'(LOCK_CNT);

  state_t           state;
  logic             div_d;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       match;

  logic             rise;
  logic             stall;
  logic             good_period;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       match_inc;
  logic [7:0]       err_cnt_inc;

  // Rise detect, stall detect and the saturating next values for the counters
  always_comb begin
    rise        = div_in & ~div_d;
    good_period = (cnt == DIV_C);
    // A stall is a full 2*DIV count with still no rise; a rise always wins
    stall       = ~rise && (cnt == STALL_C);
    match_inc   = match + 4'd1;
    err_cnt_inc = (err_cnt == 8'hff) ? err_cnt : err_cnt + 8'd1;
    if (rise) begin
      cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (cnt == CNT_MAX) begin
      cnt_next = cnt;
    end else begin
      cnt_next = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Checker state machine with all outputs registered
  always_ff @(posedge cl) begin
    if (rst) begin
      state        <= IDLE;
      div_d        <= 1'b0;
      cnt          <= '0;
      match        <= 4'd0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      err_cnt      <= 8'd0;
    end else begin
      // Edge history keeps running even in IDLE so the first rise after enable is real
      div_d        <= div_in;
      period_valid <= 1'b0;
      err          <= 1'b0;
      if (!en) begin
        // Disable parks the checker; period and err_cnt keep their last values
        state  <= IDLE;
        locked <= 1'b0;
        match  <= 4'd0;
      end else begin
        if (state != IDLE) begin
          cnt <= cnt_next;
        end
        case (state)
          IDLE: begin
            state <= ARM;
          end
          ARM: begin
            // First rise only starts the measurement; no period exists yet
            if (rise) begin
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period       <= cnt;
              period_valid <= 1'b1;
              if (good_period) begin
                match <= match_inc;
                if (match_inc == LOCK_C) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                // No lock claimed yet, so a bad period just restarts the run
                match <= 4'd0;
              end
            end else if (stall) begin
              err     <= 1'b1;
              err_cnt <= err_cnt_inc;
              locked  <= 1'b0;
              match   <= 4'd0;
              state   <= ARM;
            end
          end
          LOCKED: begin
            if (rise) begin
              period       <= cnt;
              period_valid <= 1'b1;
              if (!good_period) begin
                err     <= 1'b1;
                err_cnt <= err_cnt_inc;
                locked  <= 1'b0;
                match   <= 4'd0;
                state   <= MEASURE;
              end
            end else if (stall) begin
              // Leaving for ARM means the stall error fires only once
              err     <= 1'b1;
              err_cnt <= err_cnt_inc;
              locked  <= 1'b0;
              match   <= 4'd0;
              state   <= ARM;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_clk_checker.sv
// tb/tb_div_clk_checker.sv - directed self-checking bench for div_clk_checker
module tb_div_clk_checker;

  logic       cl = 1'b0;
  logic       rst;
  logic       en;
  logic       div_in;
  logic [7:0] period;
  logic       period_valid;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int errs_seen = 0;

  div_clk_checker #(
    .DIV      (2),
    .CNT_W    (8),
    .LOCK_CNT (4)
  ) dut (
    .cl           (cl),
    .rst          (rst),
    .en           (en),
    .div_in       (div_in),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .err          (err),
    .err_cnt      (err_cnt)
  );

  // Master clock
  always #5 cl = ~cl;

  // Drive div_in, then sample outputs 1 time unit after the edge
  task automatic tick(input logic d);
    div_in = d;
    @(posedge cl);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // n periods of 2 cycles; lock is expected on the n-th valid period when n completes a run of 4
  task automatic good_periods(input int n, input logic lock_at_end);
    for (int i = 0; i < n; i++) begin
      tick(1'b0);
      chk("good_low_pv", {31'd0, period_valid}, 32'd0);
      chk("good_low_err", {31'd0, err}, 32'd0);
      tick(1'b1);
      chk("good_pv", {31'd0, period_valid}, 32'd1);
      chk("good_period", {24'd0, period}, 32'd2);
      chk("good_err", {31'd0, err}, 32'd0);
      chk("good_locked", {31'd0, locked}, (lock_at_end && i == n - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    div_in = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b0);
    chk("rst_period", {24'd0, period}, 32'd0);
    chk("rst_pv", {31'd0, period_valid}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Healthy divide-by-two: IDLE->ARM, first rise arms, lock on 4th valid period
    rst = 1'b0;
    en  = 1'b1;
    tick(1'b0);
    tick(1'b1);
    chk("arm_no_pv", {31'd0, period_valid}, 32'd0);
    good_periods(4, 1'b1);
    chk("lock_err_cnt", {24'd0, err_cnt}, 32'd0);

    // One 3-cycle period while locked
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    chk("glitch_err", {31'd0, err}, 32'd1);
    chk("glitch_err_cnt", {24'd0, err_cnt}, 32'd1);
    chk("glitch_locked", {31'd0, locked}, 32'd0);
    chk("glitch_period", {24'd0, period}, 32'd3);
    good_periods(4, 1'b1);

    // Stall: err exactly once, on the 4th low cycle after the last rise
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      chk("stall_pre_err", {31'd0, err}, 32'd0);
      chk("stall_pre_locked", {31'd0, locked}, 32'd1);
    end
    tick(1'b0);
    chk("stall_err", {31'd0, err}, 32'd1);
    chk("stall_err_cnt", {24'd0, err_cnt}, 32'd2);
    chk("stall_locked", {31'd0, locked}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0);
      chk("stall_once", {31'd0, err}, 32'd0);
    end
    chk("stall_err_cnt_hold", {24'd0, err_cnt}, 32'd2);
    tick(1'b1);
    chk("rearm_no_pv", {31'd0, period_valid}, 32'd0);
    good_periods(4, 1'b1);

    // Enable low while locked
    en = 1'b0;
    tick(1'b0);
    chk("dis_locked", {31'd0, locked}, 32'd0);
    chk("dis_err_cnt", {24'd0, err_cnt}, 32'd2);
    chk("dis_period", {24'd0, period}, 32'd2);
    tick(1'b1);
    chk("dis_no_pv", {31'd0, period_valid}, 32'd0);
    en = 1'b1;
    tick(1'b0);
    tick(1'b1);
    chk("reen_no_pv", {31'd0, period_valid}, 32'd0);
    tick(1'b0);
    // Reset on an edge that would otherwise report a period
    rst = 1'b1;
    tick(1'b1);
    chk("mid_rst_period", {24'd0, period}, 32'd0);
    chk("mid_rst_pv", {31'd0, period_valid}, 32'd0);
    chk("mid_rst_locked", {31'd0, locked}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst = 1'b0;

    // Wrong ratio: div_in 1,1,0,0 gives period 4, no lock, no error
    tick(1'b0);
    tick(1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1);
      tick(1'b0);
      tick(1'b0);
      chk("ratio_no_err", {31'd0, err}, 32'd0);
      tick(1'b1);
      chk("ratio_pv", {31'd0, period_valid}, 32'd1);
      chk("ratio_period", {24'd0, period}, 32'd4);
      chk("ratio_locked", {31'd0, locked}, 32'd0);
      chk("ratio_err_cnt", {24'd0, err_cnt}, 32'd0);
    end

    // Repeated stall / re-arm until err_cnt saturates
    for (int i = 0; i < 100; i++) begin
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
      if (err) errs_seen++;
      tick(1'b1);
    end
    chk("sat_err_cnt_100", {24'd0, err_cnt}, 32'd100);
    for (int i = 0; i < 200; i++) begin
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
      if (err) errs_seen++;
      tick(1'b1);
    end
    chk("sat_err_pulses", errs_seen, 32'd300);
    chk("sat_err_cnt", {24'd0, err_cnt}, 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
